// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Bundles the fetch unit's two buses. The first is the shared
//               read strobe/address going to the four byte-lane instruction
//               memories, together with each lane's registered byte and valid.
//               The second is the valid/ready handshake that presents the
//               assembled instruction word to decode.
// Ports       : master modport = fetch unit side, slave modport = memories
//               and decode side.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
    logic        mem_rd_en;
    logic [8:0]  mem_rd_addr;
    logic [7:0]  lane0_data;
    logic [7:0]  lane1_data;
    logic [7:0]  lane2_data;
    logic [7:0]  lane3_data;
    logic        lane0_valid;
    logic        lane1_valid;
    logic        lane2_valid;
    logic        lane3_valid;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [31:0] instr_pc;

    modport master (
        output mem_rd_en, mem_rd_addr, instr_valid, instr_word, instr_pc,
        input  lane0_data, lane1_data, lane2_data, lane3_data,
        input  lane0_valid, lane1_valid, lane2_valid, lane3_valid,
        input  instr_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, instr_valid, instr_word, instr_pc,
        output lane0_data, lane1_data, lane2_data, lane3_data,
        output lane0_valid, lane1_valid, lane2_valid, lane3_valid,
        output instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Holds the fetch PC and issues one read that is shared by the
//               four byte-lane memories. It assembles the returned bytes into
//               a 32-bit word and presents that word to decode over a
//               valid/ready handshake. It also handles PC redirects and
//               records lane-protocol and alignment faults in sticky flags.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               redirect_valid  - load redirect_pc this cycle (top priority)
//               redirect_pc     - new PC, low two bits forced to zero
//               bus (master)    - lane read bus plus decode handshake
//               lane_err        - sticky, lane valids missing or disagreeing
//               misalign_err    - sticky, redirect target not word aligned
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 redirect_valid,
    input  wire logic [31:0]          redirect_pc,
    instr_fetch_unit_if.master        bus,
    output logic                      lane_err,
    output logic                      misalign_err
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        r_instr_valid;
    logic        w_instr_valid_next;
    logic [31:0] r_instr_word;
    logic [31:0] w_instr_word_next;
    logic [31:0] r_instr_pc;
    logic [31:0] w_instr_pc_next;
    logic        r_lane_err;
    logic        w_lane_err_next;
    logic        r_misalign_err;
    logic        w_misalign_err_next;
    logic        w_all_valid;
    logic        w_rd_en;

    assign w_all_valid = bus.lane0_valid & bus.lane1_valid &
                         bus.lane2_valid & bus.lane3_valid;

    // Strobe in FETCH, or in OUT when decode takes the word. In OUT the pc is
    // already incremented, so the next read goes out back to back. A redirect
    // cancels the strobe because the pc is about to change.
    assign w_rd_en = !rst && !redirect_valid &&
                     ((r_state == S_FETCH) ||
                      ((r_state == S_OUT) && bus.instr_ready));

    assign bus.mem_rd_en   = w_rd_en;
    assign bus.mem_rd_addr = rst ? 9'd0 : r_pc[10:2];
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr_word  = r_instr_word;
    assign bus.instr_pc    = r_instr_pc;
    assign lane_err        = r_lane_err;
    assign misalign_err    = r_misalign_err;

    always_comb begin
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_instr_valid_next  = r_instr_valid;
        w_instr_word_next   = r_instr_word;
        w_instr_pc_next     = r_instr_pc;
        w_lane_err_next     = r_lane_err;
        w_misalign_err_next = r_misalign_err;

        case (r_state)
            S_FETCH: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_all_valid) begin
                    w_instr_word_next  = {bus.lane3_data, bus.lane2_data,
                                          bus.lane1_data, bus.lane0_data};
                    w_instr_pc_next    = r_pc;
                    w_pc_next          = r_pc + c_PC_STEP;
                    w_instr_valid_next = 1'b1;
                    w_state_next       = S_OUT;
                end else begin
                    // Retry the same word; pc has not moved yet.
                    w_lane_err_next = 1'b1;
                    w_state_next    = S_FETCH;
                end
            end
            S_OUT: begin
                if (bus.instr_ready) begin
                    w_instr_valid_next = 1'b0;
                    w_state_next       = S_WAIT;
                end
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        // A redirect overrides everything above. Any lane response due this
        // cycle is dropped, and the lane_err update from WAIT is undone.
        if (redirect_valid) begin
            w_pc_next          = {redirect_pc[31:2], 2'b00};
            w_instr_valid_next = 1'b0;
            w_lane_err_next    = r_lane_err;
            w_state_next       = S_FETCH;
            if (redirect_pc[1:0] != 2'b00) begin
                w_misalign_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_FETCH;
            r_pc           <= RESET_PC;
            r_instr_valid  <= 1'b0;
            r_instr_word   <= 32'd0;
            r_instr_pc     <= 32'd0;
            r_lane_err     <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_instr_valid  <= w_instr_valid_next;
            r_instr_word   <= w_instr_word_next;
            r_instr_pc     <= w_instr_pc_next;
            r_lane_err     <= w_lane_err_next;
            r_misalign_err <= w_misalign_err_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-side initiator for the four byte-lane instruction memories. Holds the 32-bit PC and issues one shared read to all four lanes. Collects each lane's registered byte and valid, assembles the 32-bit instruction word, and presents it to decode over a valid/ready handshake. Supports PC redirect (branch/jump) with flush of in-flight and held words, and reports lane-protocol and alignment faults.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  load new PC this cycle
- redirect_pc  in  32  new PC
- mem_rd_en  out  1  read strobe, wired to all four lanes
- mem_rd_addr  out  9  lane word index = pc[10:2], shared by all lanes
- lane0_data / lane1_data / lane2_data / lane3_data  in  8 each  lane bytes, mapped to instr_word[7:0] / [15:8] / [23:16] / [31:24]
- lane0_valid .. lane3_valid  in  1 each  lane valid outputs; one cycle after a strobe
- instr_valid  out  1  instr_word/instr_pc valid
- instr_ready  in  1  decode accepts the word
- instr_word  out  32  assembled instruction
- instr_pc  out  32  PC of instr_word
- lane_err  out  1  sticky: lane valids disagreed or were missing in WAIT
- misalign_err  out  1  sticky: redirect_pc[1:0] != 0

## Operation
- State machine: FETCH, WAIT, OUT.
- FETCH
  - mem_rd_en=1, mem_rd_addr=pc[10:2].
  - Go to WAIT.
- WAIT
  - Lanes respond this cycle.
  - If all four lane valids=1: capture instr_word={lane3,lane2,lane1,lane0}, instr_pc=pc, pc<=pc+4, go to OUT.
  - Otherwise set lane_err, leave pc unchanged, go to FETCH (retry).
- OUT
  - instr_valid=1; word and PC held stable while instr_ready=0.
  - On instr_ready=1: mem_rd_en=1 with the already-incremented pc (back-to-back issue), go to WAIT.
  - On instr_ready=0: stay in OUT.
- Redirect (any state, highest priority)
  - pc<={redirect_pc[31:2],2'b00}.
  - instr_valid=0 from the next cycle.
  - Any in-flight lane response is discarded and does not set lane_err.
  - Go to FETCH.
  - mem_rd_en=0 in the redirect cycle, including OUT with instr_ready=1.
  - If redirect_pc[1:0]!=0, set misalign_err.
  - A word presented with instr_valid=1 in the redirect cycle counts as accepted if instr_ready=1 that cycle.
- PC arithmetic
  - 32-bit modulo 2^32.
  - mem_rd_addr uses pc[10:2] only, so it wraps 0x1FF->0x000 at pc 0x7FC->0x800 while pc keeps counting.
- Sticky flags clear only on rst.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, instr_valid=0, instr_word=0, instr_pc=0, lane_err=0, misalign_err=0; mem_rd_en=0 and mem_rd_addr=0 while rst=1.
- mem_rd_en and mem_rd_addr are combinational from state, pc, instr_ready and redirect_valid.
- All other outputs are registered.
- Cycle 0 is the first cycle with rst=0:
  - cycle 0: strobe
  - cycle 1: lanes valid, capture
  - cycle 2: instr_valid=1
- Latency from strobe to instr_valid is 2 cycles.
- With instr_ready held high, throughput is 1 word per 2 cycles (OUT, WAIT, OUT, ...).
- After a redirect at cycle r: strobe at r+1, instr_valid at r+3.
- rst mid-operation overrides everything, including a simultaneous redirect. Outputs take reset values the next cycle.

## Test plan
- Reset release with RESET_PC=0; lane model returns bytes 0x78,0x00,0x38,0xF8 at index 0 (lane0..lane3) -> strobe at cycle 0 with addr 0; instr_valid at cycle 2 with word 0xF8380078, instr_pc 0.
- instr_ready tied 1 over 4 words -> addrs 0,1,2,3; instr_pc 0,4,8,12; instr_valid pattern 1,0,1,0.
- instr_ready low for 5 cycles in OUT -> word and PC stable, no strobe; strobe in the same cycle ready rises.
- redirect_pc=0x7FC, then ready=1 -> addr 0x1FF, instr_pc 0x7FC; next addr 0x000, instr_pc 0x800.
- Redirect in WAIT to 0x103 -> misalign_err=1, captured word dropped, next addr 0x040, instr_pc 0x100; lane_err stays 0.
- lane2_valid forced 0 in WAIT -> lane_err=1, refetch of the same addr, correct word on retry; rst pulse then clears lane_err and returns pc to RESET_PC.
